// File: rtl/ifetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_unit
// Description : Instruction fetch unit. Drives the program counter, issues one
//               instruction-memory read at a time and buffers the returned
//               {pc, instruction} pairs in a 2-entry FIFO for decode. Handles
//               branch/jump redirects, including responses that are still in
//               flight when the redirect arrives.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst          clock, synchronous active-high reset
//   pc_in             current PC from the external PC register (0x60 after reset)
//   pc_load/pc_next   load strobe and next value for the PC register
//   redirect_valid/pc single-cycle branch/jump redirect and its target
//   imem_read/addr    instruction memory request, held until imem_resp
//   imem_rdata/resp   instruction memory read data and single-cycle completion
//   inst_valid/pc/data head of the instruction FIFO handed to decode
//   inst_ready        decode accepts the head instruction
//   perf_fetch_cnt    instructions pushed into the FIFO
//   perf_discard_cnt  memory responses dropped because of a redirect
// Configuration
//   IFETCH_PERF_EN    when defined, the performance counters are implemented;
//                     otherwise both counter outputs are tied to zero.
// ============================================================================
module ifetch_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pc_in,
    output logic             pc_load,
    output logic [WIDTH-1:0] pc_next,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             imem_read,
    output logic [WIDTH-1:0] imem_addr,
    input  logic [WIDTH-1:0] imem_rdata,
    input  logic             imem_resp,
    output logic             inst_valid,
    output logic [WIDTH-1:0] inst_pc,
    output logic [WIDTH-1:0] inst_data,
    input  logic             inst_ready,
    output logic [31:0]      perf_fetch_cnt,
    output logic [31:0]      perf_discard_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] addr_q;          // address of the request in flight
    logic [WIDTH-1:0] fifo_pc_q   [2];
    logic [WIDTH-1:0] fifo_inst_q [2];
    logic             rd_ptr_q;
    logic             wr_ptr_q;
    logic [1:0]       count_q;
    logic [1:0]       count_d;

    logic             push;
    logic             pop;
    logic             drop;
    logic             has_room;

    // A response is only kept when it belongs to the current PC stream.
    assign push = (state_q == ST_FETCH) & imem_resp & ~redirect_valid;
    assign pop  = inst_valid & inst_ready;

    // Responses that complete a request made obsolete by a redirect.
    assign drop = imem_resp & (((state_q == ST_FETCH) & redirect_valid) |
                               (state_q == ST_DISCARD));

    // A redirect flushes the FIFO, overriding any push/pop this cycle.
    assign count_d  = redirect_valid ? 2'd0
                                     : (count_q + {1'b0, push} - {1'b0, pop});
    assign has_room = ~count_d[1];

    // Outputs are forced quiet while reset is held, independent of the
    // (possibly stale) state registers.
    assign imem_read  = ~rst & (state_q != ST_IDLE);
    assign imem_addr  = (state_q == ST_DISCARD) ? addr_q : pc_in;
    assign pc_load    = ~rst & (redirect_valid | push);
    assign pc_next    = redirect_valid ? redirect_pc : (pc_in + WIDTH'(4));
    assign inst_valid = ~rst & (count_q != 2'd0) & ~redirect_valid;
    assign inst_pc    = fifo_pc_q[rd_ptr_q];
    assign inst_data  = fifo_inst_q[rd_ptr_q];

    // Fetch control FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
        end else begin
            // pc_in is stable for the whole FETCH request, so tracking it
            // every FETCH cycle leaves the request address here if a
            // redirect moves us to DISCARD.
            if (state_q == ST_FETCH) begin
                addr_q <= pc_in;
            end
            case (state_q)
                ST_IDLE: begin
                    if (has_room) begin
                        state_q <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (redirect_valid) begin
                        // Unfinished request must still be drained.
                        state_q <= imem_resp ? ST_FETCH : ST_DISCARD;
                    end else if (imem_resp) begin
                        state_q <= has_room ? ST_FETCH : ST_IDLE;
                    end
                end
                ST_DISCARD: begin
                    if (imem_resp) begin
                        state_q <= ST_FETCH;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // FIFO bookkeeping
    always_ff @(posedge clk) begin
        if (rst || redirect_valid) begin
            count_q  <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
        end else begin
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    // FIFO storage; contents only matter while counted, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc_q[wr_ptr_q]   <= pc_in;
            fifo_inst_q[wr_ptr_q] <= imem_rdata;
        end
    end

`ifdef IFETCH_PERF_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] discard_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q   <= 32'd0;
            discard_cnt_q <= 32'd0;
        end else begin
            if (push) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (drop) begin
                discard_cnt_q <= discard_cnt_q + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt   = fetch_cnt_q;
    assign perf_discard_cnt = discard_cnt_q;
`else
    assign perf_fetch_cnt   = 32'd0;
    assign perf_discard_cnt = 32'd0;

    logic unused_perf;
    assign unused_perf = drop;
`endif

endmodule
`default_nettype wire

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 SHALL have parameter: width, 32, address/instruction width in bits.
REQ-002 SHALL have port: clk  in  1  clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port: pc_in  in  width  current PC from PC register (combinational bypass output, 0x00000060 after reset).
REQ-005 SHALL have port: pc_load  out  1  PC register load strobe.
REQ-006 SHALL have port: pc_next  out  width  value for PC register when pc_load=1.
REQ-007 SHALL have port: redirect_valid  in  1  branch/jump redirect, single-cycle.
REQ-008 SHALL have port: redirect_pc  in  width  redirect target.
REQ-009 SHALL have port: imem_read  out  1  instruction memory read request.
REQ-010 SHALL have port: imem_addr  out  width  read address.
REQ-011 SHALL have port: imem_rdata  in  width  read data, valid when imem_resp=1.
REQ-012 SHALL have port: imem_resp  in  1  single-cycle read completion.
REQ-013 SHALL have ports: inst_valid  out  1; inst_pc  out  width; inst_data  out  width  instruction handed to decode.
REQ-014 SHALL have port: inst_ready  in  1  decode accepts head instruction.
REQ-015 SHALL have ports: perf_fetch_cnt  out  32; perf_discard_cnt  out  32  performance counters.

Function
REQ-016 SHALL implement FSM states IDLE, FETCH, DISCARD, plus a 2-entry FIFO of {pc, inst}; at most one memory transaction outstanding.
REQ-017 SHALL hold imem_read=1 with imem_addr stable from request start until the cycle imem_resp=1, inclusive; imem_read=1 only in FETCH and DISCARD.
REQ-018 SHALL drive imem_addr=pc_in in FETCH and the latched address of the outstanding request in DISCARD.
REQ-019 SHALL define cnt_after = count + push - pop; pop = inst_valid & inst_ready; push = FETCH & imem_resp & !redirect_valid.
REQ-020 IDLE: go FETCH when cnt_after<2; else stay.
REQ-021 FETCH, imem_resp=1, no redirect: push {pc_in, imem_rdata}; pc_load=1, pc_next=pc_in+4 (mod 2^width); next state FETCH if cnt_after<2, else IDLE.
REQ-022 FETCH, redirect_valid=1, imem_resp=0: go DISCARD; memory request continues unchanged.
REQ-023 FETCH, redirect_valid=1 and imem_resp=1 same cycle: response dropped, not pushed; go FETCH.
REQ-024 DISCARD: on imem_resp=1, drop data, go FETCH; redirect_valid in DISCARD updates PC and stays DISCARD until resp.
REQ-025 On any redirect_valid=1 (any state): pc_load=1, pc_next=redirect_pc, FIFO flushed (count=0), pop suppressed; redirect overrides the sequential advance.
REQ-026 pc_load SHALL be 0 in all cycles not covered by REQ-021/REQ-025.
REQ-027 inst_valid = (count!=0) & !redirect_valid; inst_pc/inst_data = FIFO head; data in FIFO held until popped.
REQ-028 Simultaneous push and pop with count=2 SHALL NOT occur (FETCH entered only with a free slot); push and pop in same cycle at count=1 leaves count=1 with order preserved.
REQ-029 Latency: instruction visible on inst_valid the cycle after its imem_resp.

Reset
REQ-030 On rst=1: state=IDLE, FIFO count=0, FIFO pointers=0, latched address=0, perf counters=0.
REQ-031 During rst=1 outputs SHALL be: imem_read=0, pc_load=0, inst_valid=0; first request issued in second cycle after rst deasserts, address 0x00000060.
REQ-032 rst mid-transaction SHALL abandon it; any later imem_resp arriving in IDLE is ignored.

Configuration
REQ-033 Macro IFETCH_PERF_EN: defined -> perf_fetch_cnt increments on each push, perf_discard_cnt on each dropped response (REQ-023/REQ-024), both wrap at 2^32; undefined -> both outputs tied to 0, no counter flops.

Verification
REQ-034 Reset then 1-cycle-latency memory, inst_ready=1 -> imem_addr 0x60, 0x64, 0x68...; inst_pc matches; pc_load=1 on each resp.
REQ-035 inst_ready=0, memory always ready -> exactly two instructions (0x60, 0x64) buffered, FSM IDLE, imem_read=0; raise inst_ready -> fetch resumes at 0x68.
REQ-036 Redirect to 0x200 while 0x64 outstanding (resp 3 cycles later) -> imem_addr stays 0x64 until resp, data dropped, next request 0x200, perf_discard_cnt=1 (macro on).
REQ-037 Redirect to 0x400 same cycle as resp -> response dropped, FIFO empty, next request 0x400 following cycle.
REQ-038 rst asserted with request outstanding -> imem_read=0, inst_valid=0 next cycle; late resp ignored; fetch restarts at 0x60.
REQ-039 Sequential fetch from 0xFFFFFFFC -> pc_next=0x00000000.
